// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, fetch FSM states and fetch control selects
package cpu_pkg;

  localparam logic [2:0]  OPC_HLT           = 3'b111;
  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    S_VECTOR = 2'd0,
    S_RUN    = 2'd1,
    S_HALT   = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2,
    PC_VECTOR   = 2'd3
  } pc_sel_t;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_LOAD   = 2'd1,
    IFID_SQUASH = 2'd2
  } ifid_sel_t;

  function automatic logic is_hlt(input logic [2:0] opc);
    return opc == OPC_HLT;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - fetch FSM: state register, next-PC select and IF/ID load/hold/squash select
module fetch_ctrl
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic         redirect_en_i,
  input  logic         hlt_fetched_i,
  output fetch_state_t state_o,
  output pc_sel_t      pc_sel_o,
  output ifid_sel_t    ifid_sel_o
);

  fetch_state_t state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_VECTOR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_sel_o   = PC_HOLD;
    ifid_sel_o = IFID_HOLD;
    case (state_q)
      S_VECTOR: begin
        pc_sel_o = PC_VECTOR;
        state_d  = S_RUN;
      end
      S_RUN: begin
        if (redirect_en_i) begin
          pc_sel_o   = PC_REDIRECT;
          ifid_sel_o = IFID_SQUASH;
        end else if (flush_i) begin
          ifid_sel_o = IFID_SQUASH;
        end else if (!stall_i) begin
          ifid_sel_o = IFID_LOAD;
          // HLT still reaches decode, but the PC parks on it
          if (hlt_fetched_i) begin
            state_d = S_HALT;
          end else begin
            pc_sel_o = PC_INC;
          end
        end
      end
      S_HALT: begin
        ifid_sel_o = IFID_SQUASH;
        if (redirect_en_i) begin
          pc_sel_o = PC_REDIRECT;
          state_d  = S_RUN;
        end
      end
      default: begin
        state_d = S_VECTOR;
      end
    endcase
  end

  assign state_o = state_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem read, IF/ID register
// Optional FETCH_PERF_CNT_EN adds fetch_cnt / stall_cnt performance counters.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W         = 16,
  parameter int                 INST_W         = 16,
  parameter logic [ADDR_W-1:0]  RESET_VEC_ADDR = '0,
  parameter logic [INST_W-1:0]  NOP_INSTR      = INST_W'(NOP_INSTR_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [INST_W-1:0] instr_r,
  output logic [ADDR_W-1:0] pc_plus1_r,
  output logic              valid_r,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt,
`endif
  output logic              halted
);

  fetch_state_t state;
  pc_sel_t      pc_sel;
  ifid_sel_t    ifid_sel;

  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [INST_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_plus1_q, pc_plus1_d;
  logic              valid_q, valid_d;

  fetch_ctrl u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_en_i (redirect_en),
    .hlt_fetched_i (is_hlt(imem_rdata[INST_W-1 -: 3])),
    .state_o       (state),
    .pc_sel_o      (pc_sel),
    .ifid_sel_o    (ifid_sel)
  );

  assign pc_inc    = pc_q + ADDR_W'(1);
  assign imem_addr = (state == S_VECTOR) ? RESET_VEC_ADDR : pc_q;

  always_comb begin
    pc_d = pc_q;
    case (pc_sel)
      PC_INC:      pc_d = pc_inc;
      PC_REDIRECT: pc_d = redirect_pc;
      PC_VECTOR:   pc_d = ADDR_W'(imem_rdata);
      default:     pc_d = pc_q;
    endcase
  end

  always_comb begin
    instr_d    = instr_q;
    pc_plus1_d = pc_plus1_q;
    valid_d    = valid_q;
    case (ifid_sel)
      IFID_LOAD: begin
        instr_d    = imem_rdata;
        pc_plus1_d = pc_inc;
        valid_d    = 1'b1;
      end
      IFID_SQUASH: begin
        instr_d    = NOP_INSTR;
        pc_plus1_d = '0;
        valid_d    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      instr_q    <= NOP_INSTR;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_r    = instr_q;
  assign pc_plus1_r = pc_plus1_q;
  assign valid_r    = valid_q;
  assign halted     = (state == S_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        stall_evt;

  // a stall only counts when it actually froze the stage
  assign stall_evt = (state == S_RUN) && stall && !redirect_en && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (ifid_sel == IFID_LOAD) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_evt)             stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        stall, flush, redirect_en;
  logic [15:0] redirect_pc;
  logic [15:0] instr_r, pc_plus1_r;
  logic        valid_r, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
`endif

  logic [15:0] mem [0:65535];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr];

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .flush       (flush),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .instr_r     (instr_r),
    .pc_plus1_r  (pc_plus1_r),
    .valid_r     (valid_r),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt),
`endif
    .halted      (halted)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ifid(input string tag, input logic [15:0] ins, input logic [15:0] pp1,
                      input logic vld, input logic [15:0] addr);
    chk({tag, ".instr"}, 32'(instr_r), 32'(ins));
    chk({tag, ".pc1"},   32'(pc_plus1_r), 32'(pp1));
    chk({tag, ".valid"}, 32'(valid_r), 32'(vld));
    chk({tag, ".addr"},  32'(imem_addr), 32'(addr));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = {3'b010, i[12:0]};
    mem[16'h0000] = 16'h0010;
    mem[16'h0020] = 16'hE000;

    rst = 1'b1; stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    step();
    ifid("reset", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    chk("reset.halted", 32'(halted), 32'd0);
    rst = 1'b0;

    step();
    ifid("vector", 16'h0000, 16'h0000, 1'b0, 16'h0010);
    step();
    ifid("first", 16'h4010, 16'h0011, 1'b1, 16'h0011);
    step();
    ifid("second", 16'h4011, 16'h0012, 1'b1, 16'h0012);

    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      ifid("stall", 16'h4011, 16'h0012, 1'b1, 16'h0012);
    end
    stall = 1'b0;
    step();
    ifid("resume", 16'h4012, 16'h0013, 1'b1, 16'h0013);
`ifdef FETCH_PERF_CNT_EN
    chk("perf.fetch", fetch_cnt, 32'd3);
    chk("perf.stall", stall_cnt, 32'd3);
`endif

    flush = 1'b1;
    step();
    ifid("flush", 16'h0000, 16'h0000, 1'b0, 16'h0013);
    flush = 1'b0;
    step();
    ifid("postflush", 16'h4013, 16'h0014, 1'b1, 16'h0014);

    redirect_en = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    step();
    ifid("redir_stall", 16'h0000, 16'h0000, 1'b0, 16'h0040);
    redirect_en = 1'b0; stall = 1'b0;
    step();
    ifid("redir_tgt", 16'h4040, 16'h0041, 1'b1, 16'h0041);

    redirect_en = 1'b1; redirect_pc = 16'h001E;
    step();
    redirect_en = 1'b0;
    step();
    step();
    ifid("pre_hlt", 16'h401F, 16'h0020, 1'b1, 16'h0020);
    step();
    ifid("hlt", 16'hE000, 16'h0021, 1'b1, 16'h0020);
    chk("hlt.halted", 32'(halted), 32'd1);
    step();
    ifid("halted1", 16'h0000, 16'h0000, 1'b0, 16'h0020);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("halted2.halted", 32'(halted), 32'd1);
    chk("halted2.valid", 32'(valid_r), 32'd0);
    stall = 1'b0; flush = 1'b0;
    redirect_en = 1'b1; redirect_pc = 16'h0030;
    step();
    chk("unhalt.halted", 32'(halted), 32'd0);
    ifid("unhalt", 16'h0000, 16'h0000, 1'b0, 16'h0030);
    redirect_en = 1'b0;
    step();
    ifid("after_hlt", 16'h4030, 16'h0031, 1'b1, 16'h0031);

    redirect_en = 1'b1; redirect_pc = 16'hFFFF;
    step();
    redirect_en = 1'b0;
    chk("wrap.addr0", 32'(imem_addr), 32'h0000FFFF);
    step();
    ifid("wrap", 16'h5FFF, 16'h0000, 1'b1, 16'h0000);
    step();
    ifid("wrapped", 16'h0010, 16'h0001, 1'b1, 16'h0001);

    stall = 1'b1; rst = 1'b1;
    step();
    ifid("rst_run", 16'h0000, 16'h0000, 1'b0, 16'h0000);
    chk("rst_run.halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_run.fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_run.stall_cnt", stall_cnt, 32'd0);
`endif
    rst = 1'b0; stall = 1'b0;
    step();
    chk("revector.addr", 32'(imem_addr), 32'h00000010);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
